// File: rtl/demux_1to4_buffered_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_buffered_pkg
// Description : Shared types and constants for the buffered 1-to-4 demux.
//               Holds the lane count, the lane-index type, the lane FSM
//               state encoding and a one-hot decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_1to4_buffered_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [0:0] {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    // One-hot decode of a lane index.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_idx_t idx);
        logic [NUM_LANES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_1to4_buffered_if.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_buffered_if
// Description : Bus bundle of the buffered 1-to-4 demux.
//   in_data/in_valid/in_ready : upstream word handshake
//   sel/auto_mode             : lane selection (explicit / round-robin)
//   out_data/out_valid/out_ready : four downstream lane handshakes,
//                                  lane i data at [i*WIDTH +: WIDTH]
//   rr_ptr/route_count        : status (round-robin pointer, word count)
//   master drives the upstream side and out_ready; slave is the demux.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux_1to4_buffered_if
    import demux_1to4_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]           in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic [1:0]                 sel;
    logic                       auto_mode;
    logic [NUM_LANES*WIDTH-1:0] out_data;
    logic [NUM_LANES-1:0]       out_valid;
    logic [NUM_LANES-1:0]       out_ready;
    logic [1:0]                 rr_ptr;
    logic [CNT_W-1:0]           route_count;

    modport master (
        output in_data, in_valid, sel, auto_mode, out_ready,
        input  in_ready, out_data, out_valid, rr_ptr, route_count
    );

    modport slave (
        input  in_data, in_valid, sel, auto_mode, out_ready,
        output in_ready, out_data, out_valid, rr_ptr, route_count
    );
endinterface
`default_nettype wire

// File: rtl/demux_1to4_buffered_lane.sv
`default_nettype none
// ============================================================================
// Module      : demux_lane
// Description : One-entry lane buffer with an EMPTY/FULL FSM.
//   clock, reset : clock, asynchronous active-high reset
//   i_load       : capture i_data (caller guarantees room or a same-cycle drain)
//   i_data       : word to capture
//   i_drain      : downstream consumer takes the buffered word
//   o_data       : buffered word (holds while FULL and not drained)
//   o_valid      : buffer FULL
// Revision    : 1.0 - initial release
// ============================================================================
module demux_lane
    import demux_1to4_buffered_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_drain,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_valid
);

    lane_state_t      r_state_q, w_state_d;
    logic [WIDTH-1:0] r_data_q,  w_data_d;

    // A load wins over a drain: simultaneous drain+load replaces the word
    // and the lane stays FULL with no bubble.
    always_comb begin
        w_state_d = r_state_q;
        w_data_d  = r_data_q;
        if (i_load) begin
            w_state_d = LANE_FULL;
            w_data_d  = i_data;
        end else if (i_drain) begin
            w_state_d = LANE_EMPTY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= LANE_EMPTY;
            r_data_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_data_q  <= w_data_d;
        end
    end

    assign o_data  = r_data_q;
    assign o_valid = (r_state_q == LANE_FULL);

endmodule
`default_nettype wire

// File: rtl/demux_1to4_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux_1to4_buffered
// Description : Sequential 1-to-4 demultiplexer with one-entry lane buffers.
//   clock, reset : clock, asynchronous active-high reset
//   bus (slave)  : upstream handshake, lane selection, four lane outputs,
//                  rr_ptr and route_count status
//   Target lane is auto_mode ? rr_ptr : sel. in_ready passes the target
//   lane's downstream ready through combinationally when that lane is FULL.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1to4_buffered
    import demux_1to4_buffered_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
)
(
    input  wire logic              clock,
    input  wire logic              reset,
    demux_1to4_buffered_if.slave   bus
);

    logic [WIDTH-1:0]           w_lane_data [NUM_LANES];
    logic [NUM_LANES-1:0]       w_lane_valid;
    logic [NUM_LANES-1:0]       w_load;
    logic [NUM_LANES*WIDTH-1:0] w_out_data;
    lane_idx_t                  w_target;
    logic                       w_in_ready;
    logic                       w_accept;
    lane_idx_t                  r_rr_ptr_q, w_rr_ptr_d;
    logic [CNT_W-1:0]           r_route_count_q, w_route_count_d;

    always_comb begin
        w_target        = bus.auto_mode ? r_rr_ptr_q : lane_idx_t'(bus.sel);
        w_in_ready      = ~w_lane_valid[w_target] | bus.out_ready[w_target];
        w_accept        = bus.in_valid & w_in_ready;
        w_load          = w_accept ? lane_onehot(w_target) : '0;
        w_rr_ptr_d      = r_rr_ptr_q;
        w_route_count_d = r_route_count_q;
        if (w_accept) begin
            w_route_count_d = r_route_count_q + CNT_W'(1);
            // The pointer only advances on round-robin accepts, so it is
            // retained across explicit-select traffic.
            if (bus.auto_mode) begin
                w_rr_ptr_d = r_rr_ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr_q      <= '0;
            r_route_count_q <= '0;
        end else begin
            r_rr_ptr_q      <= w_rr_ptr_d;
            r_route_count_q <= w_route_count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            demux_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clock   (clock),
                .reset   (reset),
                .i_load  (w_load[gi]),
                .i_data  (bus.in_data),
                .i_drain (bus.out_ready[gi]),
                .o_data  (w_lane_data[gi]),
                .o_valid (w_lane_valid[gi])
            );
        end
    endgenerate

    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_out_data[i*WIDTH +: WIDTH] = w_lane_data[i];
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_data    = w_out_data;
    assign bus.out_valid   = w_lane_valid;
    assign bus.rr_ptr      = r_rr_ptr_q;
    assign bus.route_count = r_route_count_q;

endmodule
`default_nettype wire

// File: doc/demux_1to4_buffered.md
Name: demux_1to4_buffered

Overview:
- Sequential 1-to-4 demultiplexer: the distribution-side counterpart of the ALU's 4-to-1 operand/result muxing.
- Routes each accepted input word to one of four output lanes, chosen by an explicit 2-bit select or by an internal round-robin pointer.
- Each lane holds the word in a one-entry buffer with a valid/ready handshake.
- Sits between the ALU result path and four downstream consumers (register-file write ports, display latches).

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- CNT_W, 8, width of the routed-word counter (≥1).

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to route.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  the block accepts in_data this cycle.
- sel  input  2  explicit target lane; used when auto_mode=0.
- auto_mode  input  1  1 = round-robin target; 0 = sel target.
- out_data  output  4*WIDTH  lane i data at bits [i*WIDTH +: WIDTH].
- out_valid  output  4  lane i buffer full.
- out_ready  input  4  lane i consumer takes the word this cycle.
- rr_ptr  output  2  current round-robin pointer.
- route_count  output  CNT_W  number of words accepted, modulo 2^CNT_W.

Behaviour:
- Reset (async assert; release on a clean edge) values:
  - out_valid=0, out_data=0, rr_ptr=0, route_count=0.
  - in_ready follows the combinational rule below, so it reads 1 during reset.
- Target lane: t = auto_mode ? rr_ptr : sel. Evaluated combinationally each cycle from current inputs and state.
- Per-lane FSM (states EMPTY, FULL):
  - EMPTY -> FULL on accept to that lane.
  - FULL -> EMPTY on drain (out_ready[i]=1) with no simultaneous accept to that lane.
  - FULL -> FULL on simultaneous drain and accept: the new word replaces the old; no bubble, no loss.
  - FULL with out_ready[i]=0: out_data lane i and out_valid[i] stay stable.
- in_ready = (lane t EMPTY) OR (out_ready[t]=1). Combinational pass-through of downstream ready.
- Accept when in_valid & in_ready:
  - buf[t] <= in_data; lane t is FULL next cycle. Latency is exactly 1 cycle from accept to out_valid[t]=1.
  - route_count increments by 1 and wraps from 2^CNT_W-1 to 0.
  - If auto_mode=1, rr_ptr increments and wraps from 3 to 0.
- rr_ptr never changes without an accept in auto mode. It is retained while auto_mode=0.
- Toggling auto_mode between transfers takes effect in the same cycle, via the combinational target.
- Blocked target: in_valid=1, lane t FULL, out_ready[t]=0 -> in_ready=0. No state change. No word goes to another lane. No rr_ptr skip.
- Lanes drain independently. Any subset of lanes may drain in the same cycle as an accept.
- in_data is not required to stay stable after acceptance. A word presented with in_ready=0 is not captured.
- Reset asserted mid-operation: buffered words are discarded, all lanes return to EMPTY, rr_ptr and route_count return to 0.
- No combinational path from in_data to out_data. The only combinational paths are out_ready -> in_ready and sel/auto_mode -> in_ready.

Decomposition:
- Shared package holds:
  - constant NUM_LANES=4;
  - 2-bit lane-index type;
  - lane FSM state encoding (EMPTY=0, FULL=1).
- One natural sub-module: demux_lane, a one-entry buffer with the EMPTY/FULL FSM, load/drain inputs, and data/valid outputs. It is instantiated 4 times.
- The top level holds the target selection, in_ready logic, rr_ptr and route_count.

Test Plan:
- Reset then explicit routing:
  - Stimulus: auto_mode=0, out_ready=4'b0000; send 0x11 (sel=0), 0x22 (sel=1), 0x33 (sel=2), 0x44 (sel=3) on consecutive cycles.
  - Response: out_valid=4'b1111; lanes 0..3 hold 0x11, 0x22, 0x33, 0x44; route_count=4; each out_valid bit rises one cycle after its accept.
- Backpressure:
  - Stimulus: lane 2 FULL with 0x33, out_ready[2]=0, then in_valid=1, sel=2, in_data=0x55.
  - Response: in_ready=0 for every stalled cycle; lane 2 still holds 0x33. Raising out_ready[2] accepts 0x55 the same cycle, and lane 2 shows 0x55 the next cycle with out_valid[2] held at 1.
- Round-robin:
  - Stimulus: auto_mode=1, out_ready=4'b1111; send 6 words 0xA0..0xA5.
  - Response: lanes receive them in order 0,1,2,3,0,1; rr_ptr ends at 2.
- Mode switch:
  - Stimulus: switch auto_mode 1->0 with rr_ptr=2; send 2 words with sel=0; switch back to auto_mode=1.
  - Response: rr_ptr stays 2 throughout; the next auto word goes to lane 2.
- Counter wrap:
  - Stimulus: CNT_W=2; send 5 words.
  - Response: route_count sequence is 1,2,3,0,1.
- Reset mid-operation:
  - Stimulus: lanes 0 and 3 FULL, rr_ptr=3, then assert reset asynchronously between edges.
  - Response: out_valid=0, out_data=0, rr_ptr=0 and route_count=0 immediately, before the next edge; the first word after release goes to lane 0 in auto mode.
